// File: rtl/adc_ctrl_seq_pkg.sv
// Shared types and constants for the ADC sequencer.
package adc_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PWRUP = 2'd1,
    CONV  = 2'd2,
    GAP   = 2'd3
  } adc_seq_st_e;

  localparam int AvgDepth = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ast_pkg.sv
// AST-side ADC request/response types shared by the sequencer and the analog model.
package ast_pkg;

  parameter int AdcChannels  = 2;
  parameter int AdcDataWidth = 10;

  typedef struct packed {
    logic [AdcChannels-1:0] channel_sel;
    logic                   pd;
  } adc_ast_req_t;

  typedef struct packed {
    logic [AdcDataWidth-1:0] data;
    logic                    data_valid;
  } adc_ast_rsp_t;

endpackage

// File: rtl/adc_ctrl_seq_avg.sv
// Per-channel 4-sample averager; exists only when ADC_CTRL_SEQ_AVG_EN is defined.
// out_valid/out_data are combinational so the top registers them with the direct path's timing.
`ifdef ADC_CTRL_SEQ_AVG_EN
module adc_ctrl_seq_avg
  import adc_ctrl_seq_pkg::*;
#(
  parameter int DataW = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [DataW-1:0] in_data_i,
  input  logic             clr_i,
  output logic             out_valid_o,
  output logic [DataW-1:0] out_data_o
);

  localparam int AccW = DataW + 2;

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [1:0]      cnt_q, cnt_d;

  always_comb begin
    sum         = acc_q + AccW'(in_data_i);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_o = 1'b0;
    out_data_o  = sum[AccW-1:2];
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid_i) begin
      if (cnt_q == 2'(AvgDepth - 1)) begin
        out_valid_o = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/adc_ctrl_seq.sv
// Round-robin ADC sequencer: power-up, per-channel conversion with timeout, result capture.
// Optional averaging of 4 conversions per reported sample under ADC_CTRL_SEQ_AVG_EN.
module adc_ctrl_seq
  import adc_ctrl_seq_pkg::*;
#(
  parameter int NumCh      = ast_pkg::AdcChannels,
  parameter int DataW      = ast_pkg::AdcDataWidth,
  parameter int PwrUpCyc   = 16,
  parameter int TimeoutCyc = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  output ast_pkg::adc_ast_req_t    adc_o,
  input  ast_pkg::adc_ast_rsp_t    adc_i,
  output logic [NumCh*DataW-1:0]   sample_o,
  output logic [NumCh-1:0]         sample_valid_o,
  output logic                     busy_o,
  output logic                     timeout_err_o,
  input  logic                     err_clr_i
);

  localparam int CntMax = max_int(PwrUpCyc, TimeoutCyc);
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int ChW    = (NumCh > 1) ? $clog2(NumCh) : 1;

  localparam logic [CntW-1:0] PwrUpLast   = CntW'(PwrUpCyc - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCyc - 1);
  localparam logic [CntW-1:0] CntSat      = '1;
  localparam logic [ChW-1:0]  ChLast      = ChW'(NumCh - 1);

  adc_seq_st_e st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic            capture, timeout;

  logic                   pd_q, pd_d;
  logic [NumCh-1:0]       sel_q, sel_d;
  logic [NumCh*DataW-1:0] sample_q, sample_d;
  logic [NumCh-1:0]       vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

`ifdef ADC_CTRL_SEQ_AVG_EN
  logic [NumCh-1:0] avg_vld;
  logic [DataW-1:0] avg_dat [NumCh];
  logic             avg_clr;

  assign avg_clr = (st_q == OFF);

  for (genvar c = 0; c < NumCh; c++) begin : g_avg
    adc_ctrl_seq_avg #(
      .DataW(DataW)
    ) u_avg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (capture && (ch_q == ChW'(c))),
      .in_data_i  (adc_i.data),
      .clr_i      (avg_clr),
      .out_valid_o(avg_vld[c]),
      .out_data_o (avg_dat[c])
    );
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= OFF;
      cnt_q <= '0;
      ch_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
    ch_d    = ch_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (st_q)
      OFF: begin
        cnt_d = '0;
        if (en_i) st_d = PWRUP;
      end
      PWRUP: begin
        if (!en_i) begin
          st_d  = OFF;
          cnt_d = '0;
        end else if (cnt_q == PwrUpLast) begin
          st_d  = CONV;
          cnt_d = '0;
        end
      end
      // en_i is deliberately ignored here so a conversion always runs to completion.
      CONV: begin
        if (adc_i.data_valid) begin
          capture = 1'b1;
          st_d    = GAP;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          timeout = 1'b1;
          st_d    = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (en_i) begin
          st_d = CONV;
          ch_d = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
        end else begin
          st_d = OFF;
          ch_d = '0;
        end
      end
      default: st_d = OFF;
    endcase
  end

  // Outputs are computed from next state so the registered values track the state register.
  always_comb begin
    pd_d   = (st_d == OFF);
    busy_d = (st_d != OFF);
    sel_d  = '0;
    if (st_d == CONV) sel_d = NumCh'(1) << ch_d;

    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (timeout)   err_d = 1'b1;

    sample_d = sample_q;
    vld_d    = '0;
    for (int c = 0; c < NumCh; c++) begin
`ifdef ADC_CTRL_SEQ_AVG_EN
      if (avg_vld[c]) begin
        sample_d[c*DataW +: DataW] = avg_dat[c];
        vld_d[c]                   = 1'b1;
      end
`else
      if (capture && (ch_q == ChW'(c))) begin
        sample_d[c*DataW +: DataW] = adc_i.data;
        vld_d[c]                   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pd_q     <= 1'b1;
      sel_q    <= '0;
      sample_q <= '0;
      vld_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pd_q     <= pd_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign adc_o.pd          = pd_q;
  assign adc_o.channel_sel = sel_q;
  assign sample_o          = sample_q;
  assign sample_valid_o    = vld_q;
  assign busy_o            = busy_q;
  assign timeout_err_o     = err_q;

endmodule

// File: tb/tb_adc_ctrl_seq.sv
// Directed + randomized bench for adc_ctrl_seq; reference model tracks expected samples per channel.
module tb_adc_ctrl_seq;
  import ast_pkg::*;

  localparam int NumCh      = 2;
  localparam int DataW      = 10;
  localparam int PwrUpCyc   = 16;
  localparam int TimeoutCyc = 255;

  logic clk = 1'b0;
  logic rst, en, err_clr;
  adc_ast_req_t adc_req;
  adc_ast_rsp_t adc_rsp;
  logic [NumCh*DataW-1:0] sample;
  logic [NumCh-1:0] svld;
  logic busy, terr;

  int checks = 0;
  int errors = 0;

  logic [DataW-1:0] m_sample [NumCh];
  logic             m_err;
  int               m_ch;
  int               m_acc [NumCh];
  int               m_cnt [NumCh];
  logic [NumCh-1:0] m_vld;

  always #5 clk = ~clk;

  adc_ctrl_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .adc_o         (adc_req),
    .adc_i         (adc_rsp),
    .sample_o      (sample),
    .sample_valid_o(svld),
    .busy_o        (busy),
    .timeout_err_o (terr),
    .err_clr_i     (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [NumCh*DataW-1:0] m_vec();
    logic [NumCh*DataW-1:0] v;
    for (int c = 0; c < NumCh; c++) v[c*DataW +: DataW] = m_sample[c];
    return v;
  endfunction

  task automatic m_off();
    m_ch = 0;
    for (int c = 0; c < NumCh; c++) begin
      m_acc[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic m_reset();
    m_off();
    m_err = 1'b0;
    m_vld = '0;
    for (int c = 0; c < NumCh; c++) m_sample[c] = '0;
  endtask

  task automatic m_result(input int c, input bit valid, input logic [DataW-1:0] d);
    m_vld = '0;
    if (!valid) begin
      m_err = 1'b1;
    end else begin
`ifdef ADC_CTRL_SEQ_AVG_EN
      m_acc[c] += int'(d);
      m_cnt[c]++;
      if (m_cnt[c] == 4) begin
        m_sample[c] = DataW'(m_acc[c] / 4);
        m_vld[c]    = 1'b1;
        m_acc[c]    = 0;
        m_cnt[c]    = 0;
      end
`else
      m_sample[c] = d;
      m_vld[c]    = 1'b1;
`endif
    end
  endtask

  // Called one cycle after en is raised in OFF; optionally drives stray data_valid during power-up.
  task automatic power_up(input bit noise);
    int n = 0;
    step();
    chk("pd_fall", adc_req.pd, 1'b0);
    chk("busy_on", busy, 1'b1);
    while (adc_req.channel_sel == '0 && n < 64) begin
      if (noise) begin
        adc_rsp.data_valid = (n < 10);
        adc_rsp.data       = 10'h2AA;
      end
      step();
      n++;
      if (noise) chk("pwrup_dv_ignored", svld, '0);
    end
    adc_rsp.data_valid = 1'b0;
    chk("pwrup_cycles", n, PwrUpCyc);
    chk("first_sel", adc_req.channel_sel, 1 << m_ch);
  endtask

  // Starts at a negedge with the DUT in CONV; ends one cycle after GAP.
  task automatic conv(input int lat, input bit valid, input logic [DataW-1:0] d,
                      input int drop_at, input bit clr_at_to);
    int c = m_ch;
    int n = 0;
    chk("conv_sel", adc_req.channel_sel, 1 << c);
    if (valid) begin
      for (int i = 0; i < lat; i++) begin
        if (i == drop_at) en = 1'b0;
        step();
      end
      chk("sel_held", adc_req.channel_sel, 1 << c);
      adc_rsp.data_valid = 1'b1;
      adc_rsp.data       = d;
      step();
      adc_rsp.data_valid = 1'b0;
      adc_rsp.data       = DataW'($urandom);
    end else begin
      while (adc_req.channel_sel != '0 && n < 400) begin
        err_clr = clr_at_to && (n == TimeoutCyc - 1);
        step();
        n++;
      end
      err_clr = 1'b0;
      chk("timeout_cycles", n, TimeoutCyc);
    end
    m_result(c, valid, d);
    chk("gap_sel", adc_req.channel_sel, '0);
    chk("gap_pd", adc_req.pd, 1'b0);
    chk("gap_vld", svld, m_vld);
    chk("gap_sample", sample, m_vec());
    chk("gap_err", terr, m_err);
    if (en) m_ch = (m_ch + 1) % NumCh;
    else m_off();
    step();
    if (en) begin
      chk("next_sel", adc_req.channel_sel, 1 << m_ch);
      chk("vld_cleared", svld, '0);
    end else begin
      chk("off_pd", adc_req.pd, 1'b1);
      chk("off_busy", busy, 1'b0);
      chk("off_sel", adc_req.channel_sel, '0);
    end
  endtask

  initial begin
    logic [DataW-1:0] d;
    bit               v;
    rst = 1'b1;
    en = 1'b0;
    err_clr = 1'b0;
    adc_rsp = '0;
    m_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_pd", adc_req.pd, 1'b1);
    chk("rst_sel", adc_req.channel_sel, '0);
    chk("rst_sample", sample, '0);
    chk("rst_vld", svld, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", terr, 1'b0);

    // First conversion after power-up
    en = 1'b1;
    power_up(1'b0);
    conv(5, 1'b1, 10'h155, -1, 1'b0);
`ifndef ADC_CTRL_SEQ_AVG_EN
    chk("first_sample_ch0", sample[DataW-1:0], 10'h155);
`endif

    // Alternating full-scale / minimum data
    conv(5, 1'b1, 10'h001, -1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      conv(3 + r, 1'b1, 10'h3FF, -1, 1'b0);
      conv(4, 1'b1, 10'h001, -1, 1'b0);
    end

    // Timeout on ch1, clear, then data arriving on the last legal cycle
    conv(2, 1'b1, DataW'($urandom), -1, 1'b0);
    conv(0, 1'b0, '0, -1, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr", terr, 1'b0);
    conv(TimeoutCyc - 2, 1'b1, DataW'($urandom), -1, 1'b0);
    conv(0, 1'b0, '0, -1, 1'b1);
    conv(7, 1'b1, DataW'($urandom), -1, 1'b0);

    // Reset while ch1 is selected
    rst = 1'b1;
    en = 1'b0;
    step();
    m_reset();
    chk("midrst_pd", adc_req.pd, 1'b1);
    chk("midrst_sel", adc_req.channel_sel, '0);
    chk("midrst_sample", sample, '0);
    chk("midrst_err", terr, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // en_i drop mid-conversion finishes the conversion then goes OFF
    en = 1'b1;
    power_up(1'b0);
    conv(6, 1'b1, DataW'($urandom), 2, 1'b0);
    repeat (3) step();
    chk("stay_off_pd", adc_req.pd, 1'b1);
    chk("stay_off_busy", busy, 1'b0);

    // Randomized conversions with stray data_valid during power-up
    en = 1'b1;
    power_up(1'b1);
    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 7) != 0);
      d = DataW'($urandom);
      conv(int'($urandom_range(0, 40)), v, d, (i == 23) ? 0 : -1, 1'b0);
    end

    // Averaging pattern on ch0: 10, 11, 12, 14
    en = 1'b1;
    power_up(1'b0);
    conv(1, 1'b1, 10'd10, -1, 1'b0);
    conv(1, 1'b1, DataW'($urandom), -1, 1'b0);
    conv(2, 1'b1, 10'd11, -1, 1'b0);
    conv(1, 1'b1, DataW'($urandom), -1, 1'b0);
    conv(3, 1'b1, 10'd12, -1, 1'b0);
    conv(1, 1'b1, DataW'($urandom), -1, 1'b0);
    conv(4, 1'b1, 10'd14, -1, 1'b0);
`ifdef ADC_CTRL_SEQ_AVG_EN
    chk("avg_ch0", sample[DataW-1:0], 10'd11);
`else
    chk("last_ch0", sample[DataW-1:0], 10'd14);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
